// File: rtl/dsp_pkg.sv
// Shared DSP datapath definitions.
//   ACC_WORD_WIDTH : width of one accumulator result word {accx[31:0], accy[31:0]}
//   acc_word_t     : accumulator result word type
package dsp_pkg;
   localparam int ACC_WORD_WIDTH = 64;
   typedef logic [ACC_WORD_WIDTH-1:0] acc_word_t;
endpackage

// File: rtl/accbuf_fifo.sv
// Small synchronous FIFO with first-word-fall-through head data.
//   clk, reset_n : clock, async active-low reset
//   flush        : sync empty (wins over push/pop)
//   push, wdata  : write request; ignored when full unless popped the same edge
//   pop          : read request; ignored when empty
//   full, empty  : status
//   head         : oldest entry, valid whenever empty=0
module accbuf_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AW:0]      wp_q, wp_d, rp_q, rp_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty = (wp_q == rp_q);
   assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign head  = mem_q[rp_q[AW-1:0]];

   always_comb begin
      do_pop  = pop && !empty;
      // A pop frees the slot this same edge, so a push into a full FIFO is kept.
      do_push = push && (!full || do_pop);
      wp_d    = wp_q + {{AW{1'b0}}, do_push};
      rp_d    = rp_q + {{AW{1'b0}}, do_pop};
      if (flush) begin
         wp_d = '0;
         rp_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
      end
   end

   // Storage needs no reset: only entries between rp and wp are ever read.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wp_q[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/accbuf_wr_arb.sv
// Shares one accumulator-buffer BRAM write port among NCH channels.
// Each channel's results land in a per-channel FIFO; the FIFOs are drained
// round-robin, one word per cycle, into a region of the address space
// selected by channel index.
//   clk, reset_n : DSP clock, async active-low reset
//   resetacc     : sync clear of FIFOs, counts, flags, rr pointer
//   in_valid     : per-channel result strobe
//   in_data      : channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_we/out_addr/out_data : registered BRAM write port
//   wr_count     : words written per channel, (CH_AW+1) bits each
//   full_ch      : region full, further results discarded
//   ovf          : sticky FIFO-overflow drop flag
module accbuf_wr_arb
   import dsp_pkg::*;
#(
   parameter int NCH        = 4,
   parameter int DATA_WIDTH = ACC_WORD_WIDTH,
   parameter int ADDR_WIDTH = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                         clk,
   input  logic                                         reset_n,
   input  logic                                         resetacc,
   input  logic [NCH-1:0]                               in_valid,
   input  logic [NCH*DATA_WIDTH-1:0]                    in_data,
   output logic                                         out_we,
   output logic [ADDR_WIDTH-1:0]                        out_addr,
   output logic [DATA_WIDTH-1:0]                        out_data,
   output logic [NCH*(ADDR_WIDTH-$clog2(NCH)+1)-1:0]    wr_count,
   output logic [NCH-1:0]                               full_ch,
   output logic [NCH-1:0]                               ovf
);
   localparam int IW    = $clog2(NCH);
   localparam int CH_AW = ADDR_WIDTH - IW;
   localparam logic [CH_AW:0] FULL_CNT = {1'b1, {CH_AW{1'b0}}};

   logic [NCH-1:0]                 fifo_full, fifo_empty, push, pop;
   logic [NCH-1:0][DATA_WIDTH-1:0] head;

   logic [IW-1:0]                  rr_q, rr_d, cand, gnt_idx;
   logic                           gnt_vld;
   logic [NCH-1:0][CH_AW:0]        wr_cnt_q, wr_cnt_d;
   logic [NCH-1:0]                 full_q, full_d, ovf_q, ovf_d;
   logic                           out_we_q, out_we_d;
   logic [ADDR_WIDTH-1:0]          out_addr_q, out_addr_d;
   logic [DATA_WIDTH-1:0]          out_data_q, out_data_d;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      accbuf_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk     (clk),
         .reset_n (reset_n),
         .flush   (resetacc),
         .push    (push[i]),
         .wdata   (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
         .pop     (pop[i]),
         .full    (fifo_full[i]),
         .empty   (fifo_empty[i]),
         .head    (head[i])
      );
      assign wr_count[i*(CH_AW+1) +: CH_AW+1] = wr_cnt_q[i];
   end

   // Round-robin: scan from rr_q upward (index wraps naturally, NCH is a
   // power of two) and take the first non-empty FIFO.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < NCH; k++) begin
         cand = rr_q + IW'(k);
         if (!gnt_vld && !fifo_empty[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   always_comb begin
      rr_d       = rr_q;
      wr_cnt_d   = wr_cnt_q;
      full_d     = full_q;
      ovf_d      = ovf_q;
      out_we_d   = 1'b0;
      out_addr_d = out_addr_q;
      out_data_d = out_data_q;
      push       = '0;
      pop        = '0;
      if (resetacc) begin
         rr_d     = '0;
         wr_cnt_d = '0;
         full_d   = '0;
         ovf_d    = '0;
      end else begin
         push = in_valid;
         if (gnt_vld) begin
            pop[gnt_idx] = 1'b1;
            rr_d         = gnt_idx + 1'b1;
            // Once a region is full its results are popped and thrown away
            // so the channel cannot stall the shared port.
            if (!full_q[gnt_idx]) begin
               out_we_d          = 1'b1;
               out_addr_d        = {gnt_idx, wr_cnt_q[gnt_idx][CH_AW-1:0]};
               out_data_d        = head[gnt_idx];
               wr_cnt_d[gnt_idx] = wr_cnt_q[gnt_idx] + 1'b1;
            end
         end
         for (int i = 0; i < NCH; i++) begin
            if (in_valid[i] && fifo_full[i] && !pop[i]) ovf_d[i] = 1'b1;
            full_d[i] = (wr_cnt_d[i] == FULL_CNT);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_q       <= '0;
         wr_cnt_q   <= '0;
         full_q     <= '0;
         ovf_q      <= '0;
         out_we_q   <= 1'b0;
         out_addr_q <= '0;
         out_data_q <= '0;
      end else begin
         rr_q       <= rr_d;
         wr_cnt_q   <= wr_cnt_d;
         full_q     <= full_d;
         ovf_q      <= ovf_d;
         out_we_q   <= out_we_d;
         out_addr_q <= out_addr_d;
         out_data_q <= out_data_d;
      end
   end

   assign out_we   = out_we_q;
   assign out_addr = out_addr_q;
   assign out_data = out_data_q;
   assign full_ch  = full_q;
   assign ovf      = ovf_q;
endmodule
